// File: rtl/h3_hash_pipe_elastic.sv
// h3_hash_pipe_elastic: elastic pipelined H3 (seed-XOR) hash with a run-time loadable seed table.
// Define H3_KEY_PASSTHRU_EN to carry the full key through the pipe and expose it on hash_key.
module h3_hash_pipe_elastic #(
  parameter int DATA_WIDTH = 128,
  parameter int HASH_WIDTH = 84,
  parameter int NUM_STAGES = 8
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_key,
  input  logic                          seed_wr_en,
  output logic                          seed_wr_ready,
  input  logic [$clog2(DATA_WIDTH)-1:0] seed_wr_addr,
  input  logic [HASH_WIDTH-1:0]         seed_wr_data,
  output logic                          hash_valid,
  input  logic                          hash_ready,
  output logic [HASH_WIDTH-1:0]         hash_out,
`ifdef H3_KEY_PASSTHRU_EN
  output logic [DATA_WIDTH-1:0]         hash_key,
`endif
  output logic                          busy
);
  localparam int B = (DATA_WIDTH + NUM_STAGES - 1) / NUM_STAGES;
  localparam int L = NUM_STAGES - 1;
  logic [NUM_STAGES-1:0] v_q, v_d, v_in, adv;
  logic [HASH_WIDTH-1:0] acc_q [NUM_STAGES];
  logic [HASH_WIDTH-1:0] acc_d [NUM_STAGES];
  logic [HASH_WIDTH-1:0] acc_in [NUM_STAGES];
  logic [HASH_WIDTH-1:0] fold [NUM_STAGES];
  logic [DATA_WIDTH-1:0] key_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0] key_d [NUM_STAGES];
  logic [DATA_WIDTH-1:0] key_in [NUM_STAGES];
  logic [DATA_WIDTH-1:0] keep [NUM_STAGES];
  logic [HASH_WIDTH-1:0] seed_q [DATA_WIDTH];
  logic [HASH_WIDTH-1:0] seed_d [DATA_WIDTH];
  logic seed_acc, in_fire;
  assign busy          = |v_q;
  assign seed_wr_ready = rstb & ~busy;
  assign seed_acc      = seed_wr_en & seed_wr_ready;
  assign in_ready      = rstb & adv[0] & ~seed_acc;
  assign in_fire       = in_valid & in_ready;
  assign hash_valid    = v_q[L];
  assign hash_out      = acc_q[L];
`ifdef H3_KEY_PASSTHRU_EN
  assign hash_key      = key_q[L];
`endif
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stg
    if (g == 0) begin : g_head
      assign key_in[g] = in_key;
      assign acc_in[g] = '0;
      assign v_in[g]   = in_fire;
    end else begin : g_body
      assign key_in[g] = key_q[g-1];
      assign acc_in[g] = acc_q[g-1];
      assign v_in[g]   = v_q[g-1];
    end
`ifdef H3_KEY_PASSTHRU_EN
    assign keep[g] = '1;
`else
    // only bits still to be folded by later stages are carried forward
    assign keep[g] = ~((DATA_WIDTH'(1) << ((g + 1) * B)) - DATA_WIDTH'(1));
`endif
  end
  // stage s may advance when any stage at or after it is empty, or the consumer takes the head
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int s = L; s >= 0; s--) begin
      full   = full & v_q[s];
      adv[s] = hash_ready | ~full;
    end
  end
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      fold[s] = acc_in[s];
      for (int j = 0; j < B; j++)
        if (s * B + j < DATA_WIDTH && key_in[s][s*B+j]) fold[s] = fold[s] ^ seed_q[s*B+j];
    end
  end
  always_comb begin
    v_d   = v_q;
    acc_d = acc_q;
    key_d = key_q;
    for (int s = 0; s < NUM_STAGES; s++)
      if (adv[s]) begin
        v_d[s] = v_in[s];
        if (v_in[s]) begin
          acc_d[s] = fold[s];
          key_d[s] = key_in[s] & keep[s];
        end
      end
  end
  always_comb begin
    seed_d = seed_q;
    if (seed_acc && 32'(seed_wr_addr) < DATA_WIDTH) seed_d[seed_wr_addr] = seed_wr_data;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      v_q    <= '0;
      acc_q  <= '{default: '0};
      key_q  <= '{default: '0};
      seed_q <= '{default: '0};
    end else begin
      v_q    <= v_d;
      acc_q  <= acc_d;
      key_q  <= key_d;
      seed_q <= seed_d;
    end
  end
endmodule
